i2c_write_master: RTL and testbench
===================================

Name: i2c_write_master

Overview:
- Byte-level I2C write engine sitting directly downstream of the VGA-encoder configuration sequencer.
- The sequencer presents one {device address, register address, data} triple per `start` pulse.
- This block emits a complete I2C write on open-drain `scl`/`sda`: START, 3 bytes with ACK check each, STOP.
- It reports completion via `done` and reports a missing ACK via `ack_error`.

Parameters:
- CLK_DIV, 250: `clk` cycles per quarter SCL period (100 MHz clk -> 100 kHz SCL). Legal range 2..65535.

Ports:
- clk        input   1  system clock
- reset      input   1  synchronous, active-low reset
- start      input   1  one-cycle request; sampled only when busy=0
- dev_addr   input   7  7-bit slave address; R/W bit always 0 (write)
- reg_addr   input   8  slave register address
- wr_data    input   8  register data
- busy       output  1  high from accepted start until done
- done       output  1  one-cycle pulse at end of transaction
- ack_error  output  1  set if any byte was NACKed; held until next accepted start
- scl        inout   1  open-drain: drives 0 or Z, never 1
- sda        inout   1  open-drain: drives 0 or Z, never 1

Behaviour:
- Reset (reset=0 at a clk edge):
  - busy=0, done=0, ack_error=0.
  - scl and sda released (Z) from the next edge.
  - All counters and state return to IDLE.
  - Reset mid-transaction abandons the bus with no STOP; this is acceptable.
- Inputs are registered into an internal 27-bit shift source when start is accepted: {dev_addr,1'b0}, reg_addr, wr_data. Later input changes are ignored.
- start while busy=1: ignored, no queuing.
- Quarter tick:
  - 16-bit counter counts 0..CLK_DIV-1; tick on reaching CLK_DIV-1, then wraps to 0.
  - Counter is held at 0 in IDLE.
  - All state changes below occur on ticks.
- States:
  - IDLE: scl=Z, sda=Z. On accepted start: busy=1, ack_error=0, go to START_A.
  - START_A (1 quarter): scl=Z, sda=Z. -> START_B.
  - START_B (1 quarter): scl=Z, sda=0 (START condition). -> BIT with bit index 7, byte index 0.
  - BIT (4 quarters per bit, MSB first):
    - Q0: scl=0, sda set to the data bit (0 -> drive 0, 1 -> Z).
    - Q1, Q2: scl=Z.
    - Q3: scl=0.
    - After bit 0 -> ACK.
  - ACK (4 quarters), sda=Z throughout:
    - Q0: scl=0. Q1: scl=Z. Q2: scl=Z; sda sampled on the last cycle of Q2. Q3: scl=0.
    - If sampled sda=1 (NACK): set ack_error and go to STOP_A (abort remaining bytes).
    - Otherwise: next byte, or STOP_A after byte 2.
  - STOP_A: scl=0, sda=0. STOP_B: scl=Z, sda=0. STOP_C: scl=Z, sda=Z (STOP). One quarter each. -> DONE.
  - DONE: done=1 for exactly one clk; busy=0 on the same cycle. -> IDLE.
- Latency (all ACKs received): done asserts 113*CLK_DIV clk cycles after the cycle start was sampled (2 + 27*4 + 3 quarters).
- Latency (NACK on byte n, n=0..2): done asserts (2 + 36*(n+1) + 3)*CLK_DIV cycles after start.
- A new start is accepted on the cycle after done.
- sda transitions only while scl is driven low, except the START and STOP edges.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - In BIT Q1 and ACK Q1, the quarter counter holds at 0 while the sampled scl input reads 0.
  - The slave may therefore stretch the clock indefinitely; timing resumes one clk after scl reads 1.
  - Latencies above are minimums.
- Undefined: the scl input is never read; timing is fixed.

Test Plan:
- CLK_DIV=4, pullups on scl/sda, slave model ACKs all bytes; start with dev_addr=7'h39, reg_addr=8'h1C, wr_data=8'h04:
  - decoded bytes are 8'h72, 8'h1C, 8'h04;
  - one START and one STOP;
  - done pulses once at cycle 452 after start; ack_error=0.
- Same as above, but the slave NACKs byte 1:
  - STOP follows the second ACK slot; wr_data is never driven;
  - done at cycle (2+72+3)*4=308; ack_error=1.
- start pulsed again at cycles 10 and 200 during a transaction -> ignored; exactly one done.
- reset=0 at cycle 150 mid-byte:
  - next cycle busy=0 and scl=sda=Z;
  - a fresh start after release completes normally.
- Back-to-back: second start on the cycle after done -> accepted; busy stays 0 for exactly one cycle (the done cycle).
- With I2C_CLK_STRETCH_EN defined: slave holds scl low 40 cycles during byte 0 bit 3 -> done delayed by exactly 40 cycles versus the unstretched run; data still correct.

Source files
------------

// File: rtl/i2c_write_master.sv
// ---------------------------------------------------------------------------
// i2c_write_master
//
// Byte-level I2C write engine. Each accepted `start` produces one complete
// write transaction on the open-drain bus:
//   START, {dev_addr,W}, ACK, reg_addr, ACK, wr_data, ACK, STOP.
// A NACK on any byte aborts the remaining bytes, goes straight to STOP and
// raises ack_error.
//
// Timing is built from "quarters" of an SCL period, each CLK_DIV clk cycles
// long. The quarters are START_A, START_B, 4 per data/ACK bit, and
// STOP_A/B/C.
//
// Optional feature (macro I2C_CLK_STRETCH_EN): when defined, the quarter
// counter stalls in the high phase (Q1) of every data/ACK bit while the scl
// line reads low. This lets a slave stretch the clock. When the macro is
// undefined, the scl input is never read and timing is fixed.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   start      one-cycle request, honoured only while busy=0
//   dev_addr   7-bit slave address (the R/W bit is always 0)
//   reg_addr   slave register address
//   wr_data    register data
//   busy       high from the accepted start until done
//   done       one-cycle pulse at the end of the transaction
//   ack_error  a byte was NACKed; held until the next accepted start
//   scl, sda   open-drain bus lines (drive 0 or Z only)
// ---------------------------------------------------------------------------
module i2c_write_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    inout  wire        scl,
    inout  wire        sda
);

    localparam logic [15:0] CLK_DIV_M1 = 16'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE,
        START_A,
        START_B,
        BIT,
        ACK,
        STOP_A,
        STOP_B,
        STOP_C,
        DONE
    } state_t;

    state_t      state_reg;
    logic [15:0] quarter_cnt_reg;
    logic [1:0]  phase_reg;       // quarter within a data or ACK bit
    logic [2:0]  bit_idx_reg;     // current data bit, 7 = MSB
    logic [1:0]  byte_idx_reg;
    // Serial source: each byte is followed by a '1' that stands for the
    // released ACK slot, so one left shift per bit (data or ACK) keeps the
    // next data bit at the MSB.
    logic [26:0] shift_reg;
    logic        nack_reg;
    logic        scl_low_reg;
    logic        sda_low_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        ack_error_reg;

    logic        stall;
    logic        tick;

    assign scl = scl_low_reg ? 1'b0 : 1'bz;
    assign sda = sda_low_reg ? 1'b0 : 1'bz;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ack_error = ack_error_reg;

`ifdef I2C_CLK_STRETCH_EN
    // The scl line is sampled directly so that timing resumes on the first
    // clk after the slave releases it.
    assign stall = ((state_reg == BIT) || (state_reg == ACK)) &&
                   (phase_reg == 2'd1) && (scl == 1'b0);
`else
    assign stall = 1'b0;
`endif

    assign tick = !stall && (quarter_cnt_reg == CLK_DIV_M1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            quarter_cnt_reg <= '0;
            phase_reg       <= '0;
            bit_idx_reg     <= '0;
            byte_idx_reg    <= '0;
            shift_reg       <= '0;
            nack_reg        <= 1'b0;
            scl_low_reg     <= 1'b0;
            sda_low_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            ack_error_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if ((state_reg == IDLE) || (state_reg == DONE) || stall || tick) begin
                quarter_cnt_reg <= '0;
            end else begin
                quarter_cnt_reg <= quarter_cnt_reg + 16'd1;
            end

            case (state_reg)
                // DONE also accepts a start, so a request presented during
                // the done cycle is taken on the very next edge.
                IDLE, DONE: begin
                    scl_low_reg <= 1'b0;
                    sda_low_reg <= 1'b0;
                    if (start) begin
                        shift_reg     <= {dev_addr, 1'b0, 1'b1,
                                          reg_addr, 1'b1,
                                          wr_data, 1'b1};
                        busy_reg      <= 1'b1;
                        ack_error_reg <= 1'b0;
                        state_reg     <= START_A;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                START_A: begin
                    if (tick) begin
                        sda_low_reg <= 1'b1;      // START: sda falls, scl high
                        state_reg   <= START_B;
                    end
                end

                START_B: begin
                    if (tick) begin
                        scl_low_reg  <= 1'b1;
                        sda_low_reg  <= ~shift_reg[26];
                        phase_reg    <= 2'd0;
                        bit_idx_reg  <= 3'd7;
                        byte_idx_reg <= 2'd0;
                        state_reg    <= BIT;
                    end
                end

                BIT: begin
                    if (tick) begin
                        case (phase_reg)
                            2'd0: begin
                                scl_low_reg <= 1'b0;
                                phase_reg   <= 2'd1;
                            end
                            2'd1: phase_reg <= 2'd2;
                            2'd2: begin
                                scl_low_reg <= 1'b1;
                                phase_reg   <= 2'd3;
                            end
                            default: begin
                                // scl stays low into the next Q0, so sda may
                                // change here.
                                shift_reg <= {shift_reg[25:0], 1'b1};
                                phase_reg <= 2'd0;
                                if (bit_idx_reg == 3'd0) begin
                                    sda_low_reg <= 1'b0;
                                    state_reg   <= ACK;
                                end else begin
                                    bit_idx_reg <= bit_idx_reg - 3'd1;
                                    sda_low_reg <= ~shift_reg[25];
                                end
                            end
                        endcase
                    end
                end

                ACK: begin
                    if (tick) begin
                        case (phase_reg)
                            2'd0: begin
                                scl_low_reg <= 1'b0;
                                phase_reg   <= 2'd1;
                            end
                            2'd1: phase_reg <= 2'd2;
                            2'd2: begin
                                nack_reg    <= sda;   // last cycle of Q2
                                scl_low_reg <= 1'b1;
                                phase_reg   <= 2'd3;
                            end
                            default: begin
                                shift_reg <= {shift_reg[25:0], 1'b1};
                                phase_reg <= 2'd0;
                                if (nack_reg || (byte_idx_reg == 2'd2)) begin
                                    if (nack_reg) begin
                                        ack_error_reg <= 1'b1;
                                    end
                                    sda_low_reg <= 1'b1;
                                    state_reg   <= STOP_A;
                                end else begin
                                    byte_idx_reg <= byte_idx_reg + 2'd1;
                                    bit_idx_reg  <= 3'd7;
                                    sda_low_reg  <= ~shift_reg[25];
                                    state_reg    <= BIT;
                                end
                            end
                        endcase
                    end
                end

                STOP_A: begin
                    if (tick) begin
                        scl_low_reg <= 1'b0;
                        state_reg   <= STOP_B;
                    end
                end

                STOP_B: begin
                    if (tick) begin
                        sda_low_reg <= 1'b0;      // STOP: sda rises, scl high
                        state_reg   <= STOP_C;
                    end
                end

                STOP_C: begin
                    if (tick) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_master
//
// Bench for i2c_write_master with CLK_DIV=4, pullups on both lines and a
// slave model that decodes bytes and ACKs or NACKs on request. Expected
// bytes are queued at launch and compared as the slave decodes them;
// latency, flags and START/STOP counts come from a vector table. Hand-made
// sequences cover ignored starts, mid-transaction reset, back-to-back
// requests and, with I2C_CLK_STRETCH_EN, clock stretching.
// ---------------------------------------------------------------------------
module tb_i2c_write_master;

    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy;
    logic       done;
    logic       ack_error;
    wire        scl_w;
    wire        sda_w;

    logic slave_sda_low = 1'b0;
    logic slave_scl_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = slave_sda_low ? 1'b0 : 1'bz;
    assign scl_w = slave_scl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl       (scl_w),
        .sda       (sda_w)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int unsigned actual,
                         input int unsigned expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    // ---------------- slave model / scoreboard ----------------
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] shreg = '0;
    logic [7:0] exp_byte;
    logic       acking = 1'b0;
    bit         sb_en = 1'b0;
    int bit_cnt = 0;
    int byte_num = 0;
    int nack_byte = -1;
    int start_cnt = 0;
    int stop_cnt = 0;
    int nbytes = 0;
    int done_pulses = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (scl_w && prev_scl && prev_sda && !sda_w) begin
            start_cnt++;
            bit_cnt = 0;
            byte_num = 0;
            acking = 1'b0;
            slave_sda_low = 1'b0;
        end else if (scl_w && prev_scl && !prev_sda && sda_w) begin
            stop_cnt++;
        end else if (scl_w && !prev_scl) begin
            if (bit_cnt < 8) begin
                shreg = {shreg[6:0], sda_w};
                bit_cnt++;
                if (bit_cnt == 8) begin
                    nbytes++;
                    if (sb_en) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            $display("FAIL byte: got 0x%02h expected none", shreg);
                        end else begin
                            exp_byte = exp_q.pop_front();
                            check("byte", shreg, exp_byte);
                        end
                    end
                end
            end
        end else if (!scl_w && prev_scl) begin
            if (acking) begin
                slave_sda_low = 1'b0;
                acking = 1'b0;
                bit_cnt = 0;
                byte_num++;
            end else if (bit_cnt == 8) begin
                acking = 1'b1;
                slave_sda_low = (byte_num != nack_byte);
            end
        end
        prev_scl = scl_w;
        prev_sda = sda_w;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [6:0] dev;
        logic [7:0] rega;
        logic [7:0] data;
        int         nack;    // byte index the slave NACKs, -1 = none
        bit         poke;    // extra start pulses at cycles 10 and 200
        int         lat;     // expected cycles from start edge to done
        bit         aerr;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs[NVEC];

    task automatic launch(input vec_t v);
        exp_q.delete();
        exp_q.push_back({v.dev, 1'b0});
        if (v.nack < 0 || v.nack >= 1) exp_q.push_back(v.rega);
        if (v.nack < 0 || v.nack >= 2) exp_q.push_back(v.data);
        nack_byte = v.nack;
        start_cnt = 0;
        stop_cnt = 0;
        nbytes = 0;
        done_pulses = 0;
        sb_en = 1'b1;
        dev_addr = v.dev;
        reg_addr = v.rega;
        wr_data = v.data;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // inputs after acceptance must not matter
        dev_addr = ~v.dev;
        reg_addr = ~v.rega;
        wr_data = ~v.data;
    endtask

    task automatic wait_done(input bit poke, input bit stretch,
                             output int cycles, output bit busy_ok);
        cycles = 0;
        busy_ok = 1'b1;
        while (cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            start = poke && (cycles == 10 || cycles == 200);
            if (start) begin
                dev_addr = 7'h55;
                reg_addr = 8'hAA;
                wr_data = 8'h33;
            end
            if (stretch && cycles == 74) slave_scl_low = 1'b1;
            if (stretch && cycles == 116) slave_scl_low = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit bok;
        int nb;
        launch(v);
        wait_done(v.poke, 1'b0, cyc, bok);
        check("latency", cyc, v.lat);
        check("ack_error", ack_error, v.aerr);
        check("busy_held", bok, 1);
        repeat (12) @(posedge clk);
        #1;
        nb = (v.nack < 0) ? 3 : v.nack + 1;
        check("done_pulses", done_pulses, 1);
        check("start_cnt", start_cnt, 1);
        check("stop_cnt", stop_cnt, 1);
        check("nbytes", nbytes, nb);
        check("sb_left", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("ack_error_held", ack_error, v.aerr);
        $display("txn %0d: dev=%02h reg=%02h data=%02h nack=%0d lat=%0d ack_error=%0b bytes=%0d",
                 idx, v.dev, v.rega, v.data, v.nack, cyc, ack_error, nbytes);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit bok;

        vecs[0] = '{7'h39, 8'h1C, 8'h04, -1, 1'b0, 113*CLK_DIV, 1'b0};
        vecs[1] = '{7'h39, 8'h1C, 8'h04,  1, 1'b0, (2+72+3)*CLK_DIV, 1'b1};
        vecs[2] = '{7'h7F, 8'hFF, 8'h00,  0, 1'b0, (2+36+3)*CLK_DIV, 1'b1};
        vecs[3] = '{7'h00, 8'hA5, 8'h5A,  2, 1'b0, (2+108+3)*CLK_DIV, 1'b1};
        vecs[4] = '{7'h2A, 8'h81, 8'h7E, -1, 1'b1, 113*CLK_DIV, 1'b0};
        vecs[5] = '{7'h51, 8'h00, 8'hFF, -1, 1'b0, 113*CLK_DIV, 1'b0};

        // reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_scl", scl_w, 1);
        check("rst_sda", sda_w, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // reset in the middle of a transaction
        launch(vecs[0]);
        sb_en = 1'b0;
        repeat (149) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_scl", scl_w, 1);
        check("midrst_sda", sda_w, 1);
        check("midrst_done", done, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        $display("txn reset: abandoned transaction after 150 cycles");
        run_vec(10, vecs[0]);

        // back-to-back requests
        launch(vecs[5]);
        wait_done(1'b0, 1'b0, cyc, bok);
        check("b2b_lat_a", cyc, 113*CLK_DIV);
        check("b2b_busy_done", busy, 0);
        launch(vecs[0]);
        check("b2b_busy_next", busy, 1);
        wait_done(1'b0, 1'b0, cyc, bok);
        check("b2b_lat_b", cyc, 113*CLK_DIV);
        check("b2b_sb_left", exp_q.size(), 0);
        $display("txn b2b: second latency=%0d", cyc);
        repeat (12) @(posedge clk);
        #1;

`ifdef I2C_CLK_STRETCH_EN
        // slave stretches byte 0 bit 3 high phase by 40 cycles
        launch(vecs[0]);
        wait_done(1'b0, 1'b1, cyc, bok);
        check("stretch_lat", cyc, 113*CLK_DIV + 40);
        check("stretch_ack_error", ack_error, 0);
        repeat (12) @(posedge clk);
        #1;
        check("stretch_nbytes", nbytes, 3);
        check("stretch_sb_left", exp_q.size(), 0);
        $display("txn stretch: latency=%0d", cyc);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
